// File: rtl/prog_loader_pkg.sv
// Shared constants and state encoding for the instruction-store loader.
// Opcodes are those of the 8-bit accumulator core that runs the loaded image.
package prog_loader_pkg;

  localparam int LD_ADDR_W = 4;
  localparam int LD_DATA_W = 8;
  localparam int DEPTH     = 2 ** LD_ADDR_W;

  localparam logic [LD_DATA_W-1:0] PAD_WORD = 8'hFF;

  localparam logic [2:0] OP_IN   = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_DEC  = 3'b101;
  localparam logic [2:0] OP_JNZ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FILL   = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = stream source / memory side, slave = the loader itself.
interface prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader_csum.sv
// Byte counter and mod-256 running checksum of the program stream.
// count is one bit wider than the address so a full image (16) differs from 0.
module prog_loader_csum
  import prog_loader_pkg::*;
#(
  parameter int CNT_W  = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic              bump,
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] sum
);
  logic [CNT_W-1:0]  count_d, count_q;
  logic [DATA_W-1:0] sum_d, sum_q;

  // accept: program byte taken; bump: pad location written (no checksum update)
  always_comb begin
    count_d = count_q;
    sum_d   = sum_q;
    if (clear) begin
      count_d = '0;
      sum_d   = '0;
    end else if (accept) begin
      count_d = count_q + CNT_W'(1);
      sum_d   = sum_q + data;
    end else if (bump) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

  assign count = count_q;
  assign sum   = sum_q;
endmodule

// File: rtl/prog_loader.sv
// Streams a checksummed program into the core's instruction store, pads the
// rest with HALT, then releases the core from reset and reports its halt.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = LD_ADDR_W,
  parameter int DATA_W = LD_DATA_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_reset,
  input  logic            cpu_halt,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] prog_len
);
  localparam int CNT_W = ADDR_W + 1;

  state_e            state_d, state_q;
  logic              s_ready_d, s_ready_q;
  logic              mem_we_d, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_d, mem_wdata_q;
  logic              cpu_reset_d, cpu_reset_q;
  logic              done_d, done_q;
  logic              error_d, error_q;
  logic [CNT_W-1:0]  prog_len_d, prog_len_q;

  logic              cs_clear, cs_accept, cs_bump;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] sum;
  logic              beat, full;

  prog_loader_csum #(.CNT_W(CNT_W), .DATA_W(DATA_W)) u_csum (
    .clock  (clock),
    .reset  (reset),
    .clear  (cs_clear),
    .accept (cs_accept),
    .bump   (cs_bump),
    .data   (bus.s_data),
    .count  (count),
    .sum    (sum)
  );

  assign beat = bus.s_valid && s_ready_q;
  assign full = count[ADDR_W];

  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    prog_len_d  = prog_len_q;
    cs_clear    = 1'b0;
    cs_accept   = 1'b0;
    cs_bump     = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED, ST_ERROR: begin
        if (start) begin
          state_d     = ST_LOAD;
          s_ready_d   = 1'b1;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
          cs_clear    = 1'b1;
        end
      end

      ST_LOAD: begin
        if (beat) begin
          if (!bus.s_last) begin
            if (full) begin
              state_d   = ST_ERROR;
              s_ready_d = 1'b0;
              error_d   = 1'b1;
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = count[ADDR_W-1:0];
              mem_wdata_d = bus.s_data;
              cs_accept   = 1'b1;
            end
          end else if (count == '0 || bus.s_data != sum) begin
            state_d   = ST_ERROR;
            s_ready_d = 1'b0;
            error_d   = 1'b1;
          end else begin
            // checksum byte is consumed here and never written to memory
            s_ready_d  = 1'b0;
            prog_len_d = count;
            state_d    = full ? ST_RUN : ST_FILL;
          end
        end
      end

      ST_FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = count[ADDR_W-1:0];
        mem_wdata_d = DATA_W'(PAD_WORD);
        cs_bump     = 1'b1;
        if (count[ADDR_W-1:0] == '1) state_d = ST_RUN;
      end

      ST_RUN: begin
        cpu_reset_d = 1'b0;
        // cpu_reset_q still high means the core is only now leaving reset
        if (!cpu_reset_q && cpu_halt) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      s_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      prog_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      prog_len_q  <= prog_len_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign done          = done_q;
  assign error         = error_q;
  assign prog_len      = prog_len_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed load table, hand-written corner sequences,
// and random programs checked against a byte-list model of the loader.
`timescale 1ns/1ps
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW = LD_ADDR_W;
  localparam int DW = LD_DATA_W;

  typedef struct {
    int              n;
    logic [16:0][7:0] b;
    logic [7:0]      csum;
    bit              last;
    bit              gap;
    bit              exp_err;
    int              exp_len;
    int              exp_wr;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cpu_halt = 1'b1;
  logic          cpu_reset, done, error;
  logic [AW:0]   prog_len;

  prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  prog_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bus       (bus.slave),
    .cpu_reset (cpu_reset),
    .cpu_halt  (cpu_halt),
    .done      (done),
    .error     (error),
    .prog_len  (prog_len)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         wr_cnt = 0;
  bit         bad_we = 1'b0;
  logic [7:0] shadow [DEPTH];
  int         cur_len = 0;
  vec_t       tbl [6];
  vec_t       one;

  always @(posedge clock) cyc <= cyc + 1;

  // write monitor: behaves like the instruction memory
  always @(negedge clock) begin
    if (bus.mem_we) begin
      shadow[bus.mem_addr] = bus.mem_wdata;
      wr_cnt = wr_cnt + 1;
      if (!cpu_reset || error || done) bad_we = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_s_ready"},   bus.s_ready,   0);
    chk({nm, "_mem_we"},    bus.mem_we,    0);
    chk({nm, "_mem_addr"},  bus.mem_addr,  0);
    chk({nm, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({nm, "_cpu_reset"}, cpu_reset,     1);
    chk({nm, "_done"},      done,          0);
    chk({nm, "_error"},     error,         0);
    chk({nm, "_prog_len"},  prog_len,      0);
  endtask

  // called at a negedge; returns at the negedge after the beat is taken
  task automatic send_beat(input logic [7:0] d, input bit last, input bit gap, output bit ok);
    ok = 1'b0;
    if (gap) begin
      bus.s_data = ~d;
      @(negedge clock);
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (bus.s_ready) ok = 1'b1;
      @(negedge clock);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h00;
  endtask

  task automatic run_load(input vec_t v, input string nm, input bit do_start);
    bit         ok, all_ok;
    int         acc_cyc, t;
    logic [7:0] exp_img [DEPTH];
    for (int i = 0; i < DEPTH; i++) exp_img[i] = (i < v.n) ? v.b[i] : PAD_WORD;
    if (do_start) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wr_cnt = 0;
    bad_we = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = ~exp_img[i];
    chk({nm, "_ready_on"},  bus.s_ready, 1);
    chk({nm, "_err_clr"},   error,       0);
    chk({nm, "_done_clr"},  done,        0);
    chk({nm, "_cpu_held"},  cpu_reset,   1);

    all_ok = 1'b1;
    for (int i = 0; i < v.n; i++) begin
      send_beat(v.b[i], 1'b0, v.gap && ($urandom_range(0, 1) == 1), ok);
      all_ok &= ok;
    end
    if (v.last) begin
      send_beat(v.csum, 1'b1, v.gap && ($urandom_range(0, 1) == 1), ok);
      all_ok &= ok;
    end
    acc_cyc = cyc;
    chk({nm, "_accepted"},   all_ok,      1);
    chk({nm, "_ready_drop"}, bus.s_ready, 0);

    if (v.exp_err) begin
      repeat (4) @(negedge clock);
      chk({nm, "_error"},     error,     1);
      chk({nm, "_cpu_reset"}, cpu_reset, 1);
      chk({nm, "_done"},      done,      0);
      chk({nm, "_writes"},    wr_cnt,    v.exp_wr);
      chk({nm, "_prog_len"},  prog_len,  v.exp_len);
      chk({nm, "_we_scope"},  bad_we,    0);
    end else begin
      t = 0;
      while (cpu_reset && t < 60) begin
        @(negedge clock);
        t++;
      end
      // FILL lasts 16-len cycles, then one RUN cycle still holds the core
      chk({nm, "_release_cyc"}, cyc - acc_cyc, 16 - v.exp_len + 1);
      chk({nm, "_halt_ignored"}, done, 0);
      @(negedge clock);
      chk({nm, "_done"},      done,      1);
      chk({nm, "_cpu_run"},   cpu_reset, 0);
      chk({nm, "_error"},     error,     0);
      chk({nm, "_writes"},    wr_cnt,    v.exp_wr);
      chk({nm, "_prog_len"},  prog_len,  v.exp_len);
      chk({nm, "_we_scope"},  bad_we,    0);
      for (int i = 0; i < DEPTH; i++)
        chk($sformatf("%s_mem%0d", nm, i), shadow[i], exp_img[i]);
    end
  endtask

  function automatic vec_t mkv(input int n, input logic [7:0] fill, input logic [7:0] csum,
                               input bit last, input bit gap, input bit err, input int len,
                               input int wr);
    vec_t v;
    v.n = n;
    for (int i = 0; i < 17; i++) v.b[i] = fill;
    v.csum = csum; v.last = last; v.gap = gap;
    v.exp_err = err; v.exp_len = len; v.exp_wr = wr;
    return v;
  endfunction

  // reference model: the image is the byte list, the checksum its mod-256 sum
  function automatic vec_t rand_vec(input int prev_len);
    vec_t v;
    int   s;
    bit   bad;
    v.n = $urandom_range(0, 17);
    v.last = (v.n != 17);
    s = 0;
    for (int i = 0; i < 17; i++) begin
      v.b[i] = 8'($urandom);
      if (i < v.n) s = (s + int'(v.b[i])) % 256;
    end
    v.csum = ($urandom_range(0, 3) == 0) ? (8'(s) ^ 8'($urandom_range(1, 255))) : 8'(s);
    v.gap = ($urandom_range(0, 1) == 1);
    bad = (v.n == 0) || (v.n > 16) || (v.csum != 8'(s));
    v.exp_err = bad;
    v.exp_len = bad ? prev_len : v.n;
    v.exp_wr  = bad ? ((v.n > 16) ? 16 : v.n) : 16;
    return v;
  endfunction

  initial begin
    bit ok;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("por");
    reset = 1'b1;
    @(negedge clock);
    chk("idle_hold", cpu_reset, 1);

    tbl[0] = mkv(4, 8'h00, 8'h41, 1, 0, 0, 4, 16);
    tbl[0].b[0] = {OP_IN, 5'd0};
    tbl[0].b[1] = {OP_OUT, 5'd0};
    tbl[0].b[2] = {OP_DEC, 5'd0};
    tbl[0].b[3] = {OP_JNZ, 5'd1};
    tbl[1] = mkv(2, 8'h00, 8'h00, 1, 0, 1, 4, 2);
    tbl[1].b[0] = 8'h60;
    tbl[1].b[1] = 8'h80;
    tbl[2] = mkv(17, 8'h01, 8'h00, 0, 0, 1, 4, 16);
    tbl[3] = mkv(16, 8'h01, 8'h10, 1, 0, 0, 16, 16);
    tbl[4] = tbl[0];
    tbl[4].gap = 1'b1;
    tbl[5] = mkv(0, 8'h00, 8'h00, 1, 0, 1, 4, 0);
    for (int i = 0; i < 6; i++) begin
      run_load(tbl[i], $sformatf("vec%0d", i), 1'b1);
      cur_len = tbl[i].exp_len;
    end

    // start with a coincident beat in ERROR: the beat must not be taken
    one = mkv(1, 8'hE0, 8'hE0, 1, 0, 0, 1, 16);
    start = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b1;
    chk("coinc_not_ready", bus.s_ready, 0);
    @(negedge clock);
    start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    run_load(one, "coinc", 1'b0);

    // asynchronous reset in the middle of a load
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    send_beat(8'h60, 1'b0, 1'b0, ok);
    send_beat(8'h80, 1'b0, 1'b0, ok);
    chk("pre_rst_we", bus.mem_we, 1);
    #2 reset = 1'b0;
    #1 chk_reset("async");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_load(one, "after_rst", 1'b1);
    cur_len = 1;

    for (int r = 0; r < 24; r++) begin
      vec_t v;
      v = rand_vec(cur_len);
      run_load(v, $sformatf("rnd%0d", r), 1'b1);
      cur_len = v.exp_len;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the 16x8 instruction store that the 8-bit accumulator core fetches from.
- Accepts a program as a byte stream on a valid/ready handshake and checks a trailing checksum byte.
- Writes the accepted bytes into instruction memory and pads the unused locations with HALT.
- Holds the core in reset until the image is complete and valid, then releases it and reports when the core halts.

Parameters:
- ADDR_W, 4, instruction memory address width.
- DATA_W, 8, instruction width.
- DEPTH, 16, number of instruction locations; equals 2**ADDR_W.
- PAD_WORD, 8'hFF, fill value for unused locations; opcode 3'b111 is HALT.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load; sampled only in IDLE, HALTED and ERROR.
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_last  in  1  marks the checksum byte, which is the final beat.
- s_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- cpu_reset  out  1  active-high reset to the core; 1 = core held.
- cpu_halt  in  1  halt flag from the core's control unit.
- done  out  1  core has halted after a successful load.
- error  out  1  load rejected.
- prog_len  out  ADDR_W+1  number of program bytes accepted, 0..16.

Behaviour:
- All outputs are registered.
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, prog_len=0, state=IDLE.
- Reset asserted mid-operation aborts immediately to these values. Memory contents are left undefined.
- Internal registers: 5-bit count and 8-bit sum (mod 256).
- States: IDLE, LOAD, FILL, RUN, HALTED, ERROR.

IDLE:
- cpu_reset=1.
- On start: go to LOAD, count=0, sum=0, error=0, done=0.

LOAD:
- s_ready=1. A beat is accepted when s_valid&&s_ready.
- Non-last beat with count<16:
  - Next cycle: mem_we=1, mem_addr=count[3:0], mem_wdata=s_data.
  - count+=1, sum+=s_data.
  - Write latency is 1 cycle from acceptance.
- Non-last beat with count==16 (overflow): no write, go to ERROR.
- Last beat with count==0 (empty program): go to ERROR.
- Last beat with s_data!=sum: go to ERROR.
- Last beat with s_data==sum:
  - prog_len=count.
  - If count<16, go to FILL; if count==16, go to RUN.
  - The checksum byte is never written to memory.
- s_ready drops in the cycle after the last beat or the overflow beat.
- start is ignored in LOAD.

FILL:
- s_ready=0.
- Each cycle: mem_we=1, mem_addr=count, mem_wdata=PAD_WORD, count+=1.
- After the address-15 write, go to RUN.
- Exactly 16-prog_len write cycles occur.

RUN:
- cpu_reset=0 starting the cycle after entry.
- cpu_halt is ignored in the first RUN cycle; the core is still leaving reset.
- Afterwards, cpu_halt=1 moves to HALTED.
- start is ignored.

HALTED:
- done=1 and cpu_reset=0; the core sits in its halt state.
- On start: done=0, cpu_reset=1, go to LOAD.

ERROR:
- error=1 and cpu_reset=1.
- On start: error=0, go to LOAD.

General rules:
- mem_we is never asserted outside LOAD and FILL.
- mem_addr wraps naturally at 4 bits. count uses 5 bits to distinguish 16 from 0.
- start coincident with an s_valid beat in HALTED or ERROR: the beat is not accepted, because s_ready=0 that cycle.

Decomposition:
- Package prog_loader_pkg holds:
  - the state encoding (3-bit enum);
  - PAD_WORD;
  - core opcode constants IN=3'b011, OUT=3'b100, DEC=3'b101, JNZ=3'b110, HALT=3'b111;
  - DEPTH.
- No sub-module is required. Optionally split the byte counter and checksum into prog_loader_csum (count, sum, clear, accept).

Test Plan:
- Nominal load: start, then stream 60,80,A0,C1 with checksum 41 (s_last). Expect:
  - writes at addr 0..3 with those bytes;
  - FILL writes FF to addr 4..15 (12 cycles);
  - prog_len=4;
  - cpu_reset falls 1 cycle after RUN entry;
  - cpu_halt pulse gives done=1.
- Bad checksum: stream 60,80 then checksum 00 (expected E0). Expect:
  - error=1, cpu_reset stays 1;
  - no FILL writes, prog_len unchanged.
- Overflow: stream 17 non-last bytes of 01. Expect:
  - 16 writes, then error=1 on the 17th beat;
  - 17th byte not written, s_ready drops next cycle.
- Full image: 16 bytes of 01 plus checksum 10. Expect:
  - no FILL cycles, RUN entered directly, prog_len=16.
- Back-pressure and empty program:
  - s_valid toggling every other cycle: writes only on accepted beats.
  - start then immediate s_last with 00: error=1.
- Async reset mid-LOAD after 2 bytes: outputs immediately return to reset values; a following start plus a valid 1-byte program (E0, checksum E0) loads correctly.
